opl3_reg_wr_arbiter: RTL and testbench
======================================

OPL3_REG_WR_ARBITER -- requirements
Module: opl3_reg_wr_arbiter

Interface
REQ-001 Parameter MIN_WR_GAP, default 4: idle cycles after each issued write before the next grant; legal range 1..255.
REQ-002 Parameter REG_FILE_DATA_WIDTH, default 8 (from opl3_pkg): width of register address and data fields.
REQ-003 clk  in  1  sole clock; all logic on posedge clk.
REQ-004 ic_n  in  1  reset; asynchronous assert, active-low.
REQ-005 req0_valid  in  1  requester 0 (host path) has a write pending.
REQ-006 req0_bank_num  in  1; req0_address  in  8; req0_data  in  8 -- requester 0 write payload.
REQ-007 req0_ready  out  1  requester 0 payload accepted this cycle.
REQ-008 req1_valid, req1_bank_num, req1_address, req1_data, req1_ready -- same widths and meaning for requester 1 (internal sequencer).
REQ-009 reg_wr  out  opl3_reg_wr_t  merged register write; valid is a single-cycle pulse; bank_num, address, data valid with it.
REQ-010 busy  out  1  high in any state other than IDLE.
REQ-011 last_grant  out  1  index of the requester most recently accepted.

Function
REQ-012 FSM states IDLE, ISSUE, GAP, encoded in a single state register.
REQ-013 IDLE: if any reqN_valid is high, grant one requester, assert its reqN_ready combinationally in that cycle, capture its payload, and go to ISSUE; otherwise stay in IDLE.
REQ-014 Only one reqN_ready is high in any cycle; reqN_ready is never high outside IDLE.
REQ-015 ISSUE: reg_wr.valid = 1 for exactly one cycle with the captured payload; load the gap counter with MIN_WR_GAP-1; go to GAP.
REQ-016 GAP: decrement the counter each cycle; when the counter equals 0, go to IDLE on the next edge.
REQ-017 Latency: acceptance in cycle N gives reg_wr.valid in cycle N+1.
REQ-018 Spacing: consecutive reg_wr.valid pulses are at least MIN_WR_GAP+2 cycles apart; with continuous requests the spacing is exactly MIN_WR_GAP+2.
REQ-019 Requester payload needs to be stable only in the acceptance cycle; reg_wr fields hold their captured values until the next acceptance.
REQ-020 Dropping reqN_valid without a handshake is legal and loses no state.
REQ-021 A write to address 0x04 with data[7] = 1 (IRQ reset) is passed through unmodified; the arbiter never inspects or alters payloads.
REQ-022 last_grant updates in the acceptance cycle and is otherwise held.

Reset
REQ-023 While ic_n = 0: state = IDLE, gap counter = 0, reg_wr = 0, req0_ready = req1_ready = 0, busy = 0, last_grant = 1.
REQ-024 Reset asserted in ISSUE or GAP discards any in-flight write; no reg_wr.valid pulse occurs during or after reset for that write.
REQ-025 In the first cycle after ic_n deasserts, the block is in IDLE and may grant.

Configuration
REQ-026 Macro OPL3_REG_WR_ARB_RR_EN selects the arbitration policy.
REQ-027 With OPL3_REG_WR_ARB_RR_EN defined: round-robin arbitration; on simultaneous valid, grant the requester not equal to last_grant.
REQ-028 Without OPL3_REG_WR_ARB_RR_EN: fixed priority; requester 0 always wins on simultaneous valid; last_grant is still maintained.

Verification
REQ-029 Single write: req0 with bank 0, address 0x02, data 0xFF, held valid from idle -> req0_ready in the same cycle; reg_wr.valid one cycle later with {0, 0x02, 0xFF}; busy high for MIN_WR_GAP+1 cycles.
REQ-030 Back-to-back: req0 holds valid for 3 writes with MIN_WR_GAP = 4 -> exactly 3 reg_wr pulses, each 6 cycles apart, payloads in order.
REQ-031 Contention: both requesters valid continuously for 4 grants -> RR build grants 0,1,0,1 (from reset, last_grant = 1); fixed-priority build grants 0,0,0,0 and req1_ready never asserts.
REQ-032 Reset mid-GAP: ic_n pulsed low 2 cycles after a reg_wr pulse -> busy = 0 and reg_wr.valid = 0 immediately; after release, a pending req1 is accepted in the first cycle.
REQ-033 Reset in ISSUE: ic_n low during the ISSUE cycle -> no reg_wr.valid observed for that write.
REQ-034 Withdrawn request: req1_valid high for one cycle while in GAP, then low -> no req1_ready and no reg_wr pulse results.

Source files
------------

// File: rtl/opl3_reg_wr_arbiter.sv
// OPL3 register-write arbiter.
// Merges two register-write requesters (host path and internal sequencer)
// into one register-write stream. After every issued write it enforces a
// minimum idle gap before the next grant.
// Optional feature macro: OPL3_REG_WR_ARB_RR_EN
//   defined   -> round-robin arbitration between the two requesters
//   undefined -> fixed priority, requester 0 wins on simultaneous requests

package opl3_pkg;

  // Width of register address and data fields.
  localparam int REG_FILE_DATA_WIDTH = 8;

  // One merged register write. valid is a single-cycle strobe.
  typedef struct packed {
    logic                           valid;
    logic                           bank_num;
    logic [REG_FILE_DATA_WIDTH-1:0] address;
    logic [REG_FILE_DATA_WIDTH-1:0] data;
  } opl3_reg_wr_t;

endpackage

module opl3_reg_wr_arbiter #(
  parameter int MIN_WR_GAP          = 4,
  parameter int REG_FILE_DATA_WIDTH = opl3_pkg::REG_FILE_DATA_WIDTH
) (
  input  logic                           clk,
  input  logic                           ic_n,
  // Requester 0: host path
  input  logic                           req0_valid,
  input  logic                           req0_bank_num,
  input  logic [REG_FILE_DATA_WIDTH-1:0] req0_address,
  input  logic [REG_FILE_DATA_WIDTH-1:0] req0_data,
  output logic                           req0_ready,
  // Requester 1: internal sequencer
  input  logic                           req1_valid,
  input  logic                           req1_bank_num,
  input  logic [REG_FILE_DATA_WIDTH-1:0] req1_address,
  input  logic [REG_FILE_DATA_WIDTH-1:0] req1_data,
  output logic                           req1_ready,
  // Merged write stream and status
  output opl3_pkg::opl3_reg_wr_t         reg_wr,
  output logic                           busy,
  output logic                           last_grant
);

  // The counter is loaded with MIN_WR_GAP-1 in ISSUE and counts down to zero
  // in GAP, so GAP lasts exactly MIN_WR_GAP cycles. Legal gap range 1..255
  // fits in eight bits.
  localparam logic [7:0] GAP_LOAD = 8'(MIN_WR_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e                 state_q;
  logic [7:0]             gap_cnt_q;
  opl3_pkg::opl3_reg_wr_t reg_wr_q;
  logic                   last_grant_q;

  // Grant decisions for the current cycle; these double as the ready strobes.
  logic gnt0_d;
  logic gnt1_d;

  // Select which requester is accepted this cycle. Grants are only possible
  // in IDLE and never while the reset input is asserted, so a ready strobe
  // can never appear while the block is held in reset.
  always_comb begin
    gnt0_d = 1'b0;
    gnt1_d = 1'b0;
    if (ic_n && (state_q == ST_IDLE)) begin
`ifdef OPL3_REG_WR_ARB_RR_EN
      // Round robin: on a tie, serve the requester that was not served last.
      if (req0_valid && req1_valid) begin
        if (last_grant_q) begin
          gnt0_d = 1'b1;
        end else begin
          gnt1_d = 1'b1;
        end
      end else begin
        gnt0_d = req0_valid;
        gnt1_d = req1_valid;
      end
`else
      // Fixed priority: the host path always wins a tie.
      gnt0_d = req0_valid;
      gnt1_d = req1_valid & ~req0_valid;
`endif
    end else begin
      gnt0_d = 1'b0;
      gnt1_d = 1'b0;
    end
  end

  // Arbiter FSM: accept in IDLE, strobe the captured write in ISSUE, then
  // hold off further grants in GAP. The write strobe and payload are
  // registered here; the payload stays put until the next acceptance.
  always_ff @(posedge clk or negedge ic_n) begin
    if (!ic_n) begin
      state_q      <= ST_IDLE;
      gap_cnt_q    <= 8'd0;
      reg_wr_q     <= '0;
      last_grant_q <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt0_d) begin
            reg_wr_q.valid    <= 1'b1;
            reg_wr_q.bank_num <= req0_bank_num;
            reg_wr_q.address  <= req0_address;
            reg_wr_q.data     <= req0_data;
            last_grant_q      <= 1'b0;
            state_q           <= ST_ISSUE;
          end else if (gnt1_d) begin
            reg_wr_q.valid    <= 1'b1;
            reg_wr_q.bank_num <= req1_bank_num;
            reg_wr_q.address  <= req1_address;
            reg_wr_q.data     <= req1_data;
            last_grant_q      <= 1'b1;
            state_q           <= ST_ISSUE;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // The strobe has been visible for this one cycle; drop it.
          reg_wr_q.valid <= 1'b0;
          gap_cnt_q      <= GAP_LOAD;
          state_q        <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt_q == 8'd0) begin
            state_q <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
            state_q   <= ST_GAP;
          end
        end
        default: begin
          // Unreachable encoding: recover to a quiet IDLE.
          reg_wr_q.valid <= 1'b0;
          gap_cnt_q      <= 8'd0;
          state_q        <= ST_IDLE;
        end
      endcase
    end
  end

  assign req0_ready = gnt0_d;
  assign req1_ready = gnt1_d;
  assign reg_wr     = reg_wr_q;
  assign busy       = (state_q != ST_IDLE);
  assign last_grant = last_grant_q;

endmodule

// File: tb/tb_opl3_reg_wr_arbiter.sv
// Self-checking bench for opl3_reg_wr_arbiter.
// Inputs change on the falling edge; outputs are sampled 2 ns later, well
// away from the rising (active) edge.
module tb_opl3_reg_wr_arbiter;

  localparam int G = 4;
`ifdef OPL3_REG_WR_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       ic_n;
  logic       req0_valid, req0_bank_num, req0_ready;
  logic [7:0] req0_address, req0_data;
  logic       req1_valid, req1_bank_num, req1_ready;
  logic [7:0] req1_address, req1_data;
  opl3_pkg::opl3_reg_wr_t reg_wr;
  logic       busy, last_grant;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  opl3_reg_wr_arbiter #(.MIN_WR_GAP(G)) dut (
    .clk(clk), .ic_n(ic_n),
    .req0_valid(req0_valid), .req0_bank_num(req0_bank_num),
    .req0_address(req0_address), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_bank_num(req1_bank_num),
    .req1_address(req1_address), .req1_data(req1_data), .req1_ready(req1_ready),
    .reg_wr(reg_wr), .busy(busy), .last_grant(last_grant)
  );

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_bank_num = 1'b0; req0_address = 8'h00; req0_data = 8'h00;
    req1_valid = 1'b0; req1_bank_num = 1'b0; req1_address = 8'h00; req1_data = 8'h00;
  endtask

  // Two cycles of reset; returns on a falling edge with ic_n released.
  task automatic do_reset();
    @(negedge clk);
    ic_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    ic_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    ic_n = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_ready0 got=%b exp=0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_ready1 got=%b exp=0", req1_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    checks++; if (reg_wr !== 18'h0) begin errors++; $display("FAIL rst_reg_wr got=%h exp=0", reg_wr); end
    checks++; if (last_grant !== 1'b1) begin errors++; $display("FAIL rst_last_grant got=%b exp=1", last_grant); end
    @(negedge clk);
    idle_inputs();
    ic_n = 1'b1;
  endtask

  task automatic test_single_write();
    int busy_cnt = 0;
    int pulses = 0;
    do_reset();
    req0_valid = 1'b1; req0_bank_num = 1'b0; req0_address = 8'h02; req0_data = 8'hFF;
    #2;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0 got=%b exp=1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1 got=%b exp=0", req1_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_accept got=%b exp=0", busy); end
    @(negedge clk);
    req0_valid = 1'b0; req0_address = 8'h55; req0_data = 8'h00;
    #2;
    checks++; if (reg_wr !== {1'b1, 1'b0, 8'h02, 8'hFF}) begin errors++; $display("FAIL single_reg_wr got=%h exp=%h", reg_wr, {1'b1, 1'b0, 8'h02, 8'hFF}); end
    for (int i = 0; i < 12; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (reg_wr.valid === 1'b1) pulses++;
      @(negedge clk);
      #2;
    end
    checks++; if (busy_cnt != G + 1) begin errors++; $display("FAIL single_busy_len got=%0d exp=%0d", busy_cnt, G + 1); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
    checks++; if ({reg_wr.address, reg_wr.data} !== 16'h02FF) begin errors++; $display("FAIL single_hold got=%h exp=02ff", {reg_wr.address, reg_wr.data}); end
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int pc[$];
    logic [16:0] pp[$];
    do_reset();
    for (int cyc = 0; cyc < 40; cyc++) begin
      req0_valid    = (k < 3);
      req0_bank_num = k[0];
      req0_address  = 8'(8'h20 + k);
      req0_data     = 8'(8'hA0 + k);
      #2;
      if (req0_ready === 1'b1) k++;
      if (reg_wr.valid === 1'b1) begin
        pc.push_back(cyc);
        pp.push_back({reg_wr.bank_num, reg_wr.address, reg_wr.data});
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    checks++;
    if (pc.size() != 3) begin
      errors++; $display("FAIL b2b_count got=%0d exp=3", pc.size());
    end else begin
      checks++; if (pc[0] != 1) begin errors++; $display("FAIL b2b_latency got=%0d exp=1", pc[0]); end
      for (int i = 1; i < 3; i++) begin
        checks++; if (pc[i] - pc[i-1] != G + 2) begin errors++; $display("FAIL b2b_spacing%0d got=%0d exp=%0d", i, pc[i] - pc[i-1], G + 2); end
      end
      for (int i = 0; i < 3; i++) begin
        logic [16:0] e;
        e = {1'(i), 8'(8'h20 + i), 8'(8'hA0 + i)};
        checks++; if (pp[i] !== e) begin errors++; $display("FAIL b2b_payload%0d got=%h exp=%h", i, pp[i], e); end
      end
    end
  endtask

  task automatic test_contention();
    int g[$];
    do_reset();
    req0_valid = 1'b1; req0_address = 8'h30; req0_data = 8'h00;
    req1_valid = 1'b1; req1_address = 8'h31; req1_data = 8'h11;
    for (int cyc = 0; cyc < 60 && g.size() < 4; cyc++) begin
      #2;
      checks++; if (req0_ready === 1'b1 && req1_ready === 1'b1) begin errors++; $display("FAIL cont_exclusive got=11 exp=one-hot"); end
      if (req0_ready === 1'b1) g.push_back(0);
      else if (req1_ready === 1'b1) g.push_back(1);
      @(negedge clk);
    end
    checks++;
    if (g.size() != 4) begin
      errors++; $display("FAIL cont_timeout got=%0d grants exp=4", g.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        int e;
        e = RR ? (i % 2) : 0;
        checks++; if (g[i] != e) begin errors++; $display("FAIL cont_grant%0d got=%0d exp=%0d", i, g[i], e); end
      end
      #2;
      checks++; if (reg_wr !== {1'b1, 1'b0, 8'(8'h30 + g[3]), (g[3] == 1) ? 8'h11 : 8'h00}) begin
        errors++; $display("FAIL cont_reg_wr got=%h", reg_wr); end
      checks++; if (last_grant !== 1'(g[3])) begin errors++; $display("FAIL cont_last_grant got=%b exp=%0d", last_grant, g[3]); end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid_gap();
    do_reset();
    req0_valid = 1'b1; req0_address = 8'h40; req0_data = 8'h44;
    #2;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL midgap_accept got=%b exp=1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    #2;
    checks++; if (reg_wr.valid !== 1'b1) begin errors++; $display("FAIL midgap_pulse got=%b exp=1", reg_wr.valid); end
    repeat (2) @(negedge clk);
    ic_n = 1'b0;
    req1_valid = 1'b1; req1_bank_num = 1'b1; req1_address = 8'h50; req1_data = 8'h55;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midgap_busy got=%b exp=0", busy); end
    checks++; if (reg_wr.valid !== 1'b0) begin errors++; $display("FAIL midgap_valid got=%b exp=0", reg_wr.valid); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL midgap_ready_in_rst got=%b exp=0", req1_ready); end
    repeat (2) @(negedge clk);
    ic_n = 1'b1;
    #2;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL midgap_first_grant got=%b exp=1", req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    #2;
    checks++; if (reg_wr !== {1'b1, 1'b1, 8'h50, 8'h55}) begin errors++; $display("FAIL midgap_req1_wr got=%h exp=%h", reg_wr, {1'b1, 1'b1, 8'h50, 8'h55}); end
  endtask

  task automatic test_reset_in_issue();
    int pulses = 0;
    do_reset();
    req0_valid = 1'b1; req0_address = 8'h04; req0_data = 8'h80;
    #2;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL issue_accept got=%b exp=1", req0_ready); end
    @(posedge clk);
    #1;
    ic_n = 1'b0;
    req0_valid = 1'b0;
    #2;
    checks++; if (reg_wr.valid !== 1'b0) begin errors++; $display("FAIL issue_valid got=%b exp=0", reg_wr.valid); end
    @(negedge clk);
    @(negedge clk);
    ic_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #2;
      if (reg_wr.valid === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL issue_no_pulse got=%0d exp=0", pulses); end
  endtask

  task automatic test_withdrawn();
    int pulses = 0;
    int readies = 0;
    do_reset();
    req0_valid = 1'b1; req0_address = 8'h70; req0_data = 8'h77;
    #2;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    req1_valid = 1'b1; req1_address = 8'h71; req1_data = 8'h17;
    #2;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL withdraw_ready got=%b exp=0", req1_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL withdraw_busy got=%b exp=1", busy); end
    @(negedge clk);
    req1_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      #2;
      if (reg_wr.valid === 1'b1) pulses++;
      if (req0_ready === 1'b1 || req1_ready === 1'b1) readies++;
      @(negedge clk);
    end
    #2;
    checks++; if (pulses != 0) begin errors++; $display("FAIL withdraw_pulses got=%0d exp=0", pulses); end
    checks++; if (readies != 0) begin errors++; $display("FAIL withdraw_readies got=%0d exp=0", readies); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL withdraw_idle got=%b exp=0", busy); end
  endtask

  // Random traffic against a timeline model: the arbiter is free again at
  // cycle accept+G+2, the strobe appears in the cycle after acceptance, and
  // busy covers the cycles strictly between acceptance and free time.
  task automatic test_random();
    int free_at = 0;
    int acc = -100;
    int win;
    logic lg = 1'b1;
    logic [16:0] held = 17'h0;
    logic [17:0] exp_wr;
    logic er0, er1, eb;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      ic_n          = ($urandom_range(0, 79) != 0);
      req0_valid    = ($urandom_range(0, 2) != 0);
      req1_valid    = ($urandom_range(0, 2) != 0);
      req0_bank_num = 1'($urandom);
      req0_address  = 8'($urandom);
      req0_data     = 8'($urandom);
      req1_bank_num = 1'($urandom);
      req1_address  = 8'($urandom);
      req1_data     = 8'($urandom);
      #2;
      win = -1;
      if (!ic_n) begin
        acc = -100; free_at = c + 1; lg = 1'b1; held = 17'h0;
        er0 = 1'b0; er1 = 1'b0; eb = 1'b0; exp_wr = 18'h0;
      end else begin
        if (c >= free_at) begin
          if (req0_valid && req1_valid) win = (RR && !lg) ? 1 : 0;
          else if (req0_valid) win = 0;
          else if (req1_valid) win = 1;
        end
        er0 = (win == 0);
        er1 = (win == 1);
        eb = (c > acc) && (c < free_at);
        exp_wr = {(acc == c - 1), held};
      end
      checks++; if (req0_ready !== er0) begin errors++; $display("FAIL rnd_ready0 cyc=%0d got=%b exp=%b", c, req0_ready, er0); end
      checks++; if (req1_ready !== er1) begin errors++; $display("FAIL rnd_ready1 cyc=%0d got=%b exp=%b", c, req1_ready, er1); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, eb); end
      checks++; if (reg_wr !== exp_wr) begin errors++; $display("FAIL rnd_reg_wr cyc=%0d got=%h exp=%h", c, reg_wr, exp_wr); end
      checks++; if (last_grant !== lg) begin errors++; $display("FAIL rnd_last_grant cyc=%0d got=%b exp=%b", c, last_grant, lg); end
      if (win == 0) begin
        acc = c; free_at = c + G + 2; lg = 1'b0; held = {req0_bank_num, req0_address, req0_data};
      end else if (win == 1) begin
        acc = c; free_at = c + G + 2; lg = 1'b1; held = {req1_bank_num, req1_address, req1_data};
      end
      @(negedge clk);
    end
    ic_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    ic_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_contention();
    test_reset_mid_gap();
    test_reset_in_issue();
    test_withdrawn();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
